// File: rtl/uart_command_initiator.sv
// Frames audio-reset / APU-reset / RAM-load commands into a UART byte stream
// and waits for the one-byte status reply, with a bounded reply timeout.
module uart_command_initiator #(
  parameter int CLOCKS_PER_BIT = 40,
  parameter int REPLY_TIMEOUT  = CLOCKS_PER_BIT * 12 * 520
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [15:0] start_address,
  input  logic [7:0]  length,
  output logic [7:0]  src_index,
  input  logic [7:0]  src_data,
  input  logic        tx_uart_idle,
  output logic [7:0]  out_uart_byte,
  output logic        out_uart_byte_ready,
  input  logic [7:0]  in_uart_byte,
  input  logic        in_uart_byte_ready,
  output logic        busy,
  output logic        done,
  output logic        status_error,
  output logic        status_timeout,
  output logic [7:0]  reply_byte,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_SEND, S_WAIT_BUSY, S_WAIT_IDLE, S_WAIT_REPLY, S_DONE
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(REPLY_TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cmd, w_cmd_nxt;
  logic [15:0] r_addr, w_addr_nxt;
  logic [7:0]  r_len, w_len_nxt;
  logic [8:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_byte, w_byte_nxt;
  logic [1:0]  r_wb_cnt, w_wb_cnt_nxt;
  logic [31:0] r_to_cnt, w_to_cnt_nxt;
  logic [7:0]  r_out_byte, w_out_byte_nxt;
  logic        r_strobe, w_strobe_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_err, w_err_nxt;
  logic        r_tmo, w_tmo_nxt;
  logic [7:0]  r_reply, w_reply_nxt;

  logic        w_is_ram;
  logic        w_data_phase;
  logic [8:0]  w_last_idx;
  logic [7:0]  w_pos;
  logic [7:0]  w_hdr_byte;

  // r_idx walks the whole frame; data position is the frame index minus the 4 header bytes.
  assign w_is_ram     = (r_cmd == 8'h10);
  assign w_last_idx   = w_is_ram ? (9'd4 + {1'b0, r_len}) : 9'd0;
  assign w_data_phase = w_is_ram && (r_idx >= 9'd4);
  assign w_pos        = r_idx[7:0] - 8'd4;

  always_comb begin
    case (r_idx[1:0])
      2'd0:    w_hdr_byte = r_cmd;
      2'd1:    w_hdr_byte = r_addr[15:8];
      2'd2:    w_hdr_byte = r_addr[7:0];
      default: w_hdr_byte = r_len;
    endcase
  end

  // Transmit handshake: a byte is offered only while tx_uart_idle=1, with a single-cycle
  // out_uart_byte_ready strobe; the transmitter signals acceptance by dropping tx_uart_idle,
  // and the next byte waits until tx_uart_idle returns high.
  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_nxt      = r_cmd;
    w_addr_nxt     = r_addr;
    w_len_nxt      = r_len;
    w_idx_nxt      = r_idx;
    w_byte_nxt     = r_byte;
    w_wb_cnt_nxt   = r_wb_cnt;
    w_to_cnt_nxt   = r_to_cnt;
    w_out_byte_nxt = r_out_byte;
    w_strobe_nxt   = 1'b0;
    w_busy_nxt     = r_busy;
    w_err_nxt      = r_err;
    w_tmo_nxt      = r_tmo;
    w_reply_nxt    = r_reply;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cmd_nxt   = cmd;
          w_addr_nxt  = start_address;
          w_len_nxt   = length;
          w_err_nxt   = 1'b0;
          w_tmo_nxt   = 1'b0;
          w_reply_nxt = 8'h00;
          w_busy_nxt  = 1'b1;
          w_idx_nxt   = 9'd0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_data_phase) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_byte_nxt  = w_hdr_byte;
          w_state_nxt = S_SEND;
        end
      end
      S_FETCH: begin
        w_byte_nxt  = src_data;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (tx_uart_idle) begin
          w_out_byte_nxt = r_byte;
          w_strobe_nxt   = 1'b1;
          w_wb_cnt_nxt   = 2'd0;
          w_state_nxt    = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!tx_uart_idle || (r_wb_cnt == 2'd3)) begin
          w_state_nxt = S_WAIT_IDLE;
        end else begin
          w_wb_cnt_nxt = r_wb_cnt + 2'd1;
        end
      end
      S_WAIT_IDLE: begin
        if (tx_uart_idle) begin
          if (r_idx != w_last_idx) begin
            w_idx_nxt   = r_idx + 9'd1;
            w_state_nxt = S_LOAD;
          end else begin
            w_to_cnt_nxt = 32'd0;
            w_state_nxt  = S_WAIT_REPLY;
          end
        end
      end
      S_WAIT_REPLY: begin
        // A reply landing on the final timeout cycle still counts as a reply.
        if (in_uart_byte_ready) begin
          w_reply_nxt = in_uart_byte;
          w_err_nxt   = (in_uart_byte != 8'h00);
          w_state_nxt = S_DONE;
        end else if (r_to_cnt == TO_LAST) begin
          w_err_nxt   = 1'b1;
          w_tmo_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 32'd1;
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cmd      <= 8'h00;
      r_addr     <= 16'h0000;
      r_len      <= 8'h00;
      r_idx      <= 9'd0;
      r_byte     <= 8'h00;
      r_wb_cnt   <= 2'd0;
      r_to_cnt   <= 32'd0;
      r_out_byte <= 8'h00;
      r_strobe   <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_tmo      <= 1'b0;
      r_reply    <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd      <= w_cmd_nxt;
      r_addr     <= w_addr_nxt;
      r_len      <= w_len_nxt;
      r_idx      <= w_idx_nxt;
      r_byte     <= w_byte_nxt;
      r_wb_cnt   <= w_wb_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_out_byte <= w_out_byte_nxt;
      r_strobe   <= w_strobe_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
      r_tmo      <= w_tmo_nxt;
      r_reply    <= w_reply_nxt;
    end
  end

  assign src_index           = w_data_phase ? w_pos : 8'h00;
  assign out_uart_byte       = r_out_byte;
  assign out_uart_byte_ready = r_strobe;
  assign busy                = r_busy;
  assign done                = (r_state == S_DONE);
  assign status_error        = r_err;
  assign status_timeout      = r_tmo;
  assign reply_byte          = r_reply;
  assign dbg_state           = r_state;

endmodule

// File: tb/tb_uart_command_initiator.sv
// Directed bench for uart_command_initiator: vector table of whole commands plus
// hand-written reset-abort and start-while-busy sequences.
module tb_uart_command_initiator;

  localparam int T = 3000;
  localparam logic [2:0] ST_WAIT_REPLY = 3'd6;

  logic        clock, reset, start;
  logic [7:0]  cmd;
  logic [15:0] start_address;
  logic [7:0]  length;
  logic [7:0]  src_index, src_data;
  logic        tx_uart_idle;
  logic [7:0]  out_uart_byte;
  logic        out_uart_byte_ready;
  logic [7:0]  in_uart_byte;
  logic        in_uart_byte_ready;
  logic        busy, done, status_error, status_timeout;
  logic [7:0]  reply_byte;
  logic [2:0]  dbg_state;

  uart_command_initiator #(.CLOCKS_PER_BIT(40), .REPLY_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .start(start), .cmd(cmd),
    .start_address(start_address), .length(length),
    .src_index(src_index), .src_data(src_data), .tx_uart_idle(tx_uart_idle),
    .out_uart_byte(out_uart_byte), .out_uart_byte_ready(out_uart_byte_ready),
    .in_uart_byte(in_uart_byte), .in_uart_byte_ready(in_uart_byte_ready),
    .busy(busy), .done(done), .status_error(status_error),
    .status_timeout(status_timeout), .reply_byte(reply_byte), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [7:0]  seed;
    int          busy_clks;
    bit          resp_en;
    int          resp_delay;
    logic [7:0]  resp_byte;
    bit          exp_err;
    bit          exp_tmo;
    logic [7:0]  exp_reply;
    int          exp_lat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // main-owned
  logic [7:0] mem [0:255];
  logic [7:0] exp_q [$];
  int         tx_busy_clks = 20;
  bit         resp_en = 0;
  int         resp_delay = 0;
  logic [7:0] resp_byte = 8'h00;
  int         stray_req = 0;
  int         base = 0;
  int         dbase = 0;
  int         gbase = 0;

  // monitor-owned
  logic [7:0] cap_byte [0:1023];
  logic [7:0] cap_sidx [0:1023];
  int         strobe_total = 0;
  int         done_total = 0;
  int         gap_viol = 0;
  int         stray_ack = 0;
  int         ncyc = 0;
  int         last_strobe = -100;
  int         wr_enter = 0;
  int         tx_left = 0;
  logic [2:0] prev_state = 3'd0;
  logic [7:0] sidx_d = 8'h00;
  bit         after_pending = 0;
  logic       d_err, d_tmo, d_busy, busy_after;
  logic [7:0] d_reply;
  int         d_lat = 0;

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // transmitter, buffer RAM, responder and capture, all sampled mid-cycle
  initial begin : monitor
    tx_uart_idle       = 1'b1;
    in_uart_byte_ready = 1'b0;
    in_uart_byte       = 8'h00;
    src_data           = 8'h00;
    forever begin
      @(negedge clock);
      ncyc++;
      src_data = mem[sidx_d];
      sidx_d   = src_index;
      in_uart_byte_ready = 1'b0;
      if (out_uart_byte_ready) begin
        if (ncyc - last_strobe < 3) gap_viol++;
        last_strobe = ncyc;
        cap_byte[strobe_total % 1024] = out_uart_byte;
        cap_sidx[strobe_total % 1024] = src_index;
        strobe_total++;
        if (tx_busy_clks > 0) begin
          tx_uart_idle = 1'b0;
          tx_left      = tx_busy_clks;
        end
      end else if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) tx_uart_idle = 1'b1;
      end
      if (dbg_state == ST_WAIT_REPLY) begin
        if (prev_state != ST_WAIT_REPLY) wr_enter = ncyc;
        if (resp_en && (ncyc - wr_enter == resp_delay)) begin
          in_uart_byte_ready = 1'b1;
          in_uart_byte       = resp_byte;
        end
      end
      if (stray_ack != stray_req) begin
        in_uart_byte_ready = 1'b1;
        in_uart_byte       = 8'h77;
        stray_ack++;
      end
      if (after_pending) begin
        busy_after    = busy;
        after_pending = 0;
      end
      if (done) begin
        done_total++;
        d_err   = status_error;
        d_tmo   = status_timeout;
        d_reply = reply_byte;
        d_busy  = busy;
        d_lat   = ncyc - wr_enter;
        after_pending = 1;
      end
      prev_state = dbg_state;
    end
  end

  // driver tasks
  task automatic launch(input vec_t v);
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ v.seed;
    tx_busy_clks = v.busy_clks;
    resp_en      = v.resp_en;
    resp_delay   = v.resp_delay;
    resp_byte    = v.resp_byte;
    exp_q.delete();
    exp_q.push_back(v.cmd);
    if (v.cmd == 8'h10) begin
      exp_q.push_back(v.addr[15:8]);
      exp_q.push_back(v.addr[7:0]);
      exp_q.push_back(v.len);
      for (int i = 0; i <= int'(v.len); i++) exp_q.push_back(mem[i]);
    end
    base  = strobe_total;
    dbase = done_total;
    gbase = gap_viol;
    cmd = v.cmd; start_address = v.addr; length = v.len; start = 1'b1;
    tick();
    start = 1'b0; cmd = 8'h00; start_address = 16'h0000; length = 8'h00;
  endtask

  task automatic wait_done();
    int i = 0;
    while (done_total == dbase && i < 20000) begin
      tick();
      i++;
    end
    repeat (3) tick();
  endtask

  task automatic check_frame(input vec_t v);
    int n = strobe_total - base;
    chk("strobe_count", 32'(n), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      chk($sformatf("tx_byte[%0d]", k), 32'(cap_byte[(base + k) % 1024]), 32'(exp_q[k]));
      if (v.cmd == 8'h10 && k >= 4)
        chk($sformatf("src_index[%0d]", k), 32'(cap_sidx[(base + k) % 1024]), 32'(k - 4));
    end
    chk("strobe_gap", 32'(gap_viol - gbase), 32'd0);
    chk("done_pulses", 32'(done_total - dbase), 32'd1);
    chk("status_error", 32'(d_err), 32'(v.exp_err));
    chk("status_timeout", 32'(d_tmo), 32'(v.exp_tmo));
    chk("reply_byte", 32'(d_reply), 32'(v.exp_reply));
    chk("busy_at_done", 32'(d_busy), 32'd1);
    chk("busy_after_done", 32'(busy_after), 32'd0);
    chk("done_latency", 32'(d_lat), 32'(v.exp_lat));
  endtask

  task automatic run_vec(input vec_t v, input bit stray_start);
    launch(v);
    if (stray_start) begin
      repeat (20) tick();
      cmd = 8'h22; start = 1'b1;
      tick();
      start = 1'b0; cmd = 8'h00;
    end
    wait_done();
    check_frame(v);
    if (!v.resp_en) begin
      stray_req++;
      repeat (10) tick();
      chk("stray_reply_done", 32'(done_total - dbase), 32'd1);
      chk("stray_reply_byte", 32'(reply_byte), 32'(v.exp_reply));
      chk("stray_reply_err", 32'(status_error), 32'(v.exp_err));
    end
  endtask

  vec_t vecs [8];
  vec_t vr, vb;

  initial begin : main
    int i;
    vecs[0] = '{8'h22, 16'h0000, 8'h00, 8'h00, 480, 1'b1, 1000, 8'h00, 1'b0, 1'b0, 8'h00, 1001};
    vecs[1] = '{8'h10, 16'h1234, 8'h00, 8'hA5, 20, 1'b1, 50, 8'h00, 1'b0, 1'b0, 8'h00, 51};
    vecs[2] = '{8'h10, 16'hBEEF, 8'hFF, 8'h00, 8, 1'b1, 30, 8'h00, 1'b0, 1'b0, 8'h00, 31};
    vecs[3] = '{8'h01, 16'h0000, 8'h00, 8'h00, 20, 1'b1, 40, 8'hFF, 1'b1, 1'b0, 8'hFF, 41};
    vecs[4] = '{8'h22, 16'h0000, 8'h00, 8'h00, 20, 1'b0, 0, 8'h00, 1'b1, 1'b1, 8'h00, T};
    vecs[5] = '{8'h5A, 16'hFFFF, 8'h07, 8'h00, 3, 1'b1, 0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1};
    vecs[6] = '{8'h22, 16'h0000, 8'h00, 8'h00, 0, 1'b1, 5, 8'h00, 1'b0, 1'b0, 8'h00, 6};
    vecs[7] = '{8'h22, 16'h0000, 8'h00, 8'h00, 20, 1'b1, T - 1, 8'h00, 1'b0, 1'b0, 8'h00, T};
    vr = '{8'h10, 16'h4321, 8'd15, 8'h5C, 8, 1'b1, 20, 8'h00, 1'b0, 1'b0, 8'h00, 21};
    vb = '{8'h10, 16'h0F0F, 8'd15, 8'h33, 8, 1'b1, 25, 8'h00, 1'b0, 1'b0, 8'h00, 26};

    reset = 1'b1; start = 1'b0; cmd = 8'h00; start_address = 16'h0000; length = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobe", 32'(out_uart_byte_ready), 32'd0);
    chk("rst_out_byte", 32'(out_uart_byte), 32'd0);
    chk("rst_src_index", 32'(src_index), 32'd0);
    chk("rst_status_error", 32'(status_error), 32'd0);
    chk("rst_status_timeout", 32'(status_timeout), 32'd0);
    chk("rst_reply_byte", 32'(reply_byte), 32'd0);

    for (int v = 0; v < 8; v++) run_vec(vecs[v], 1'b0);

    // reset in the middle of a RAM load
    launch(vr);
    i = 0;
    while (strobe_total - base < 6 && i < 5000) begin
      tick();
      i++;
    end
    chk("strobes_before_reset", 32'(strobe_total - base), 32'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (300) tick();
    chk("abort_strobes", 32'(strobe_total - base), 32'd6);
    chk("abort_no_done", 32'(done_total - dbase), 32'd0);
    chk("abort_busy_later", 32'(busy), 32'd0);

    // fresh full frame with a start pulsed mid-command
    run_vec(vb, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
